// File: rtl/mul_255x255_iter.sv
// mul_255x255_iter
//   Iterative 255x255 unsigned multiplier producing the full 510-bit product
//   for the GF(2^255-19) datapath; feeds the modular reducer directly.
//   Operand B is consumed one DIGIT_W-bit digit per cycle against full-width A.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   in_valid       operands valid
//   in_ready       block can accept operands (IDLE only)
//   in_a, in_b     255-bit multiplicand / multiplier
//   out_valid      product_result valid (DONE)
//   out_ready      downstream accepts product
//   product_result 510-bit registered product, stable while out_valid
//   busy           high in MUL or DONE
//
// Build option
//   MUL_EARLY_DONE_EN  when defined, MUL finishes as soon as the remaining
//                      B digits are all zero (latency 1..NUM_DIGITS).
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | ready for operands; in_ready=1
// MUL     | accumulating one partial product per cycle
// DONE    | product valid; waiting for out_ready

module mul_255x255_iter #(
  parameter int DIGIT_W = 51
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [254:0] in_a,
  input  logic [254:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [509:0] product_result,
  output logic         busy
);

  localparam int NUM_DIGITS = 255 / DIGIT_W;
  localparam int CNT_W      = $clog2(NUM_DIGITS);
  localparam int PP_W       = 255 + DIGIT_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [254:0]       a_q, a_d;
  logic [254:0]       b_q, b_d;
  logic [509:0]       acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [DIGIT_W-1:0] digit;
  logic [PP_W-1:0]    pp;
  logic [9:0]         shamt;
  logic [509:0]       pp_shift;
  logic [254:0]       b_shift;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;

    // Current digit is always the low slice; b_q shifts right each MUL cycle.
    digit    = b_q[DIGIT_W-1:0];
    pp       = {{DIGIT_W{1'b0}}, a_q} * {255'b0, digit};
    shamt    = 10'(cnt_q) * 10'(DIGIT_W);
    pp_shift = {{(510 - PP_W){1'b0}}, pp} << shamt;
    b_shift  = b_q >> DIGIT_W;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        // A,B < 2^255 so the sum never exceeds 510 bits.
        acc_d = acc_q + pp_shift;
        b_d   = b_shift;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
        end
`ifdef MUL_EARLY_DONE_EN
        if (b_shift == '0) begin
          state_d = ST_DONE;
        end
`endif
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign in_ready       = (state_q == ST_IDLE);
  assign out_valid      = (state_q == ST_DONE);
  assign busy           = (state_q == ST_MUL) || (state_q == ST_DONE);
  assign product_result = acc_q;

endmodule

// File: tb/tb_mul_255x255_iter.sv
// tb_mul_255x255_iter
//   Directed bench for mul_255x255_iter at the default DIGIT_W=51.
//   Expected products are written out by hand as bit patterns / shifts.

module tb_mul_255x255_iter;

  localparam int DW = 51;
  localparam int ND = 255 / DW;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [254:0] in_a;
  logic [254:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [509:0] product_result;
  logic         busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_255x255_iter #(.DIGIT_W(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_a           (in_a),
    .in_b           (in_b),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .product_result (product_result),
    .busy           (busy)
  );

  task automatic check_val(input string tag, input logic [509:0] obs, input logic [509:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  // Cycles from accept edge until out_valid is seen.
  function automatic int exp_lat(input logic [254:0] b);
    int lat;
`ifdef MUL_EARLY_DONE_EN
    lat = 1;
    for (int i = 1; i < ND; i++) begin
      if ((b >> (DW * i)) != '0) lat = i + 1;
    end
`else
    lat = ND;
`endif
    return lat;
  endfunction

  task automatic start_job(input string tag, input logic [254:0] a, input logic [254:0] b);
    @(negedge clk);
    check_val({tag, "_in_ready"}, 510'(in_ready), 510'(1));
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
  endtask

  task automatic run_job(input string tag, input logic [254:0] a, input logic [254:0] b,
                         input logic [509:0] exp);
    int lat;
    start_job(tag, a, b);
    wait_done(lat);
    check_val({tag, "_lat"}, 510'(lat), 510'(exp_lat(b)));
    check_val({tag, "_prod"}, product_result, exp);
    @(posedge clk);
    #1;
    check_val({tag, "_back_idle"}, 510'(in_ready), 510'(1));
  endtask

  initial begin
    int lat;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_a      = '0;
    in_b      = '0;
    #12;
    check_val("rst_in_ready", 510'(in_ready), 510'(1));
    check_val("rst_out_valid", 510'(out_valid), 510'(0));
    check_val("rst_busy", 510'(busy), 510'(0));
    check_val("rst_prod", product_result, 510'(0));
    @(negedge clk);
    rst = 1'b1;

    run_job("one", 255'(1), 255'(1), 510'(1));
    run_job("max", '1, '1, {{254{1'b1}}, {255{1'b0}}, 1'b1});
    run_job("top", 255'(1) << 254, 255'(1) << 254, 510'(1) << 508);
    run_job("small", 255'(3), 255'(7), 510'(21));
    run_job("dig1", 255'(5), 255'(1) << 51, 510'(5) << 51);
    run_job("max_x2", '1, 255'(2), {254'b0, {255{1'b1}}, 1'b0});
    run_job("dig3", (255'(1) << 32) + 255'(1), (255'(1) << 153) + 255'(1),
            (510'(1) << 185) + (510'(1) << 153) + (510'(1) << 32) + 510'(1));
    run_job("bzero", 255'hFFFF, 255'(0), 510'(0));

    // Back-pressure: hold DONE, ignore a new in_valid pulse.
    out_ready = 1'b0;
    start_job("hold", 255'(6), 255'(9));
    wait_done(lat);
    check_val("hold_lat", 510'(lat), 510'(exp_lat(255'(9))));
    check_val("hold_prod", product_result, 510'(54));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_val("hold_out_valid", 510'(out_valid), 510'(1));
      check_val("hold_in_ready", 510'(in_ready), 510'(0));
      check_val("hold_busy", 510'(busy), 510'(1));
      check_val("hold_stable", product_result, 510'(54));
      if (i == 3) begin
        in_a     = 255'(11);
        in_b     = 255'(13);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    check_val("hold_end_prod", product_result, 510'(54));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_val("release_in_ready", 510'(in_ready), 510'(1));
    check_val("release_out_valid", 510'(out_valid), 510'(0));
    run_job("after_hold", 255'(2), 255'(2), 510'(4));

    // Reset in the middle of MUL (cnt==2).
    start_job("rstmid", '1, '1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check_val("rstmid_busy_before", 510'(busy), 510'(1));
    check_val("rstmid_not_done", 510'(out_valid), 510'(0));
    rst = 1'b0;
    #1;
    check_val("rstmid_out_valid", 510'(out_valid), 510'(0));
    check_val("rstmid_in_ready", 510'(in_ready), 510'(1));
    check_val("rstmid_busy", 510'(busy), 510'(0));
    check_val("rstmid_prod", product_result, 510'(0));
    @(negedge clk);
    rst = 1'b1;
    run_job("post_rst", 255'(3), 255'(7), 510'(21));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_255x255_iter.md
# mul_255x255_iter

Iterative 255×255-bit unsigned multiplier that produces the full 510-bit product for the GF(2^255−19) datapath. It sits directly upstream of the modular-reduction stage: its `product_result` output feeds the reducer's 510-bit input unchanged. Operand B is consumed one digit per cycle against full-width A, trading latency for area. A valid/ready handshake is used on both sides.

## Interface
Parameters:
- DIGIT_W, 51, B digit width per cycle; legal values 15, 17, 51, 85 (must divide 255)
- NUM_DIGITS, 255/DIGIT_W, derived (localparam), default 5

Ports:
- clk  in  1  single clock; rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands (high only in IDLE)
- in_a  in  255  multiplicand A
- in_b  in  255  multiplier B
- out_valid  out  1  product_result valid
- out_ready  in  1  downstream accepts product
- product_result  out  510  A×B, registered, held stable while out_valid
- busy  out  1  high in MUL or DONE

## Operation
- States: IDLE, MUL, DONE; reset state IDLE.
- IDLE: in_ready=1. On in_valid: latch A→a_reg, B→b_reg, acc=0, cnt=0, go MUL. Otherwise stay.
- MUL, one digit per edge:
  - acc ← acc + ((a_reg × b_reg[DIGIT_W-1:0]) << (DIGIT_W×cnt))
  - b_reg ← b_reg >> DIGIT_W; cnt ← cnt+1
  - Partial product is 255+DIGIT_W bits; acc is 510 bits and never overflows, since A,B ≤ 2^255−1.
  - On the edge where cnt==NUM_DIGITS−1: go DONE.
- DONE: out_valid=1, product_result=acc. On out_ready go IDLE. While out_ready=0, hold state and all outputs unchanged.
- in_valid outside IDLE is ignored; operands are not sampled.
- No accept in the same cycle as the out handshake; IDLE is always visited for ≥1 cycle between jobs.
- Reset asserted at any time, including mid-MUL: state=IDLE immediately, acc, cnt, a_reg and b_reg cleared, job discarded.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, product_result=0.
- Accept edge E0 (in_valid & in_ready). out_valid rises after edge E0+NUM_DIGITS (5 cycles default) when early done is disabled.
- Throughput: one product per NUM_DIGITS+2 cycles with out_ready tied high.
- product_result comes from a register, with no combinational path from inputs. in_ready and out_valid are decoded from the state register only.

## Configuration
- MUL_EARLY_DONE_EN
  - Defined: at each MUL edge, if the shifted b_reg (remaining digits) is zero, go DONE on that edge regardless of cnt. B=0 or B<2^DIGIT_W therefore finishes after 1 MUL cycle, so out_valid rises after E0+1. Latency becomes data-dependent: 1..NUM_DIGITS.
  - Undefined: latency is fixed at NUM_DIGITS. The zero-detect logic is absent.
  - The product value is identical in both builds.

## Test plan
- A=1, B=1 → product_result=1, out_valid after exactly 5 cycles (1 cycle with MUL_EARLY_DONE_EN).
- A=B=2^255−1 → product_result=2^510−2^256+1, after 5 cycles in both builds (top digit nonzero).
- A=2^254, B=2^254 → product_result=2^508. Exercises the top digit shift and the top bit of acc.
- out_ready held low 10 cycles in DONE → out_valid and product_result stable, in_ready=0. A new in_valid pulse is ignored. Release → IDLE one edge later.
- rst pulled low during MUL cnt=2 → immediately out_valid=0, in_ready=1, product_result=0. The next job, A=3, B=7, yields 21.
- Random 1000 operand pairs, DIGIT_W=17 and 51, random out_ready → every product matches a reference model, in order, with no drops or duplicates.
